// File: rtl/servo_seq_pkg.sv
// Shared state encodings and debug codes for the servo command sequencer.
// Imported by the sequencer top level.
package servo_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_LOAD   = 3'b001,
        ST_SETTLE = 3'b010,
        ST_DONE   = 3'b011
    } state_t;

    localparam logic [2:0] DBG_BAD = 3'b111;

endpackage

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and a flush input.
// Depth must be a power of two so the pointers wrap naturally.
module servo_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/servo_sequencer.sv
// Multi-channel servo move sequencer: queues moves, writes one channel's
// position register per move and reports completion after a settle time.
module servo_sequencer
    import servo_seq_pkg::*;
#(
    parameter int            N_CH          = 3,
    parameter int            CW            = 3,
    parameter int            PW            = 8,
    parameter int            DEPTH         = 4,
    parameter int            TW            = 24,
    parameter int            SETTLE_CYCLES = 5000000,
    parameter logic [PW-1:0] HOME_POS      = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CW-1:0]              cmd_chan,
    input  logic [PW-1:0]              cmd_pos,
    input  logic                       abort,
    output logic [N_CH*PW-1:0]         pos_out,
    output logic [N_CH-1:0]            pos_we,
    output logic                       done,
    output logic [CW-1:0]              done_chan,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_chan,
    output logic [2:0]                 db_estado
);

    localparam int            LW       = $clog2(DEPTH) + 1;
    localparam int            FW       = CW + PW;
    localparam logic [CW:0]   NCH_L    = (CW+1)'(N_CH);
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cur_chan;
    logic [PW-1:0]   r_cur_pos;
    logic [TW-1:0]   r_timer;
    logic [N_CH-1:0] r_pos_we;
    logic            r_done;
    logic [CW-1:0]   r_done_chan;
    logic            r_err;
    logic [PW-1:0]   r_pos [N_CH];

    logic            w_full;
    logic            w_empty;
    logic            w_chan_ok;
    logic            w_push;
    logic            w_pop;
    logic [FW-1:0]   w_head;
    logic [CW-1:0]   w_head_chan;
    logic [PW-1:0]   w_head_pos;
    logic [N_CH-1:0] w_head_1hot;
    logic [LW-1:0]   w_level;

    assign cmd_ready = !w_full && !abort;
    assign w_chan_ok = ({1'b0, cmd_chan} < NCH_L);
    assign w_push    = cmd_valid && cmd_ready && w_chan_ok;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && !abort;

    servo_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (abort),
        .i_push  (w_push),
        .i_data  ({cmd_chan, cmd_pos}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_level)
    );

    assign w_head_chan = w_head[FW-1 -: CW];
    assign w_head_pos  = w_head[PW-1:0];

    always_comb begin
        w_head_1hot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_head_chan == CW'(k)) begin
                w_head_1hot[k] = 1'b1;
            end
        end
    end

    // Rejected channel ids are swallowed by the handshake; only the flag remains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (cmd_valid && cmd_ready && !w_chan_ok) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cur_chan  <= '0;
            r_cur_pos   <= '0;
            r_timer     <= '0;
            r_pos_we    <= '0;
            r_done      <= 1'b0;
            r_done_chan <= '0;
        end else begin
            r_pos_we    <= '0;
            r_done      <= 1'b0;
            r_done_chan <= '0;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_cur_chan <= w_head_chan;
                            r_cur_pos  <= w_head_pos;
                            r_pos_we   <= w_head_1hot;
                            r_state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_timer <= '0;
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_timer == SET_LAST) begin
                            r_done      <= 1'b1;
                            r_done_chan <= r_cur_chan;
                            r_state     <= ST_DONE;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The LOAD write is independent of abort so a started write always lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_pos[k] <= HOME_POS;
            end
        end else if (r_state == ST_LOAD) begin
            for (int k = 0; k < N_CH; k++) begin
                if (r_cur_chan == CW'(k)) begin
                    r_pos[k] <= r_cur_pos;
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_pos
        assign pos_out[k*PW +: PW] = r_pos[k];
    end

    always_comb begin
        unique case (r_state)
            ST_IDLE:   db_estado = 3'b000;
            ST_LOAD:   db_estado = 3'b001;
            ST_SETTLE: db_estado = 3'b010;
            ST_DONE:   db_estado = 3'b011;
            default:   db_estado = DBG_BAD;
        endcase
    end

    assign pos_we    = r_pos_we;
    assign done      = r_done;
    assign done_chan = r_done_chan;
    assign err_chan  = r_err;
    assign level     = w_level;
    assign busy      = (r_state != ST_IDLE) || (w_level != '0);

endmodule
